// File: rtl/mux_sel_ctrl.sv
// Select generator for mux_2_to_1_gate: a debounced pushbutton and an optional auto-alternate timer both toggle s.
// Build with MUX_SEL_CTRL_TOGGLE_COUNT_EN defined to add the 8-bit toggle_cnt output.
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 10,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       auto_en,
    input  logic       hold,
    output logic       s,
    output logic       s_changed
`ifdef MUX_SEL_CTRL_TOGGLE_COUNT_EN
    ,
    output logic [7:0] toggle_cnt
`endif
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AP_LAST = CNT_W'(AUTO_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             s_q, s_d;
    logic             s_changed_q, s_changed_d;
    logic             btn_sync;
    logic             press_evt;
    logic             auto_evt;
    logic             toggle;

    assign btn_sync = sync2_q;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
    end

    // A press is confirmed on the cycle the FSM leaves PRESS_CHK, so press_evt is combinational.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_evt = 1'b0;
        case (state_q)
            RELEASED: begin
                if (btn_sync) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = ONE;
                end
            end
            PRESS_CHK: begin
                if (!btn_sync) begin
                    state_d  = RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = PRESSED;
                    db_cnt_d  = '0;
                    press_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d  = RELEASE_CHK;
                    db_cnt_d = ONE;
                end
            end
            RELEASE_CHK: begin
                if (btn_sync) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = RELEASED;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + ONE;
                end
            end
            default: begin
                state_d  = RELEASED;
                db_cnt_d = '0;
            end
        endcase
    end

    // Hold freezes the period counter outright; a press restarts the period only when not held.
    always_comb begin
        auto_evt  = auto_en && !hold && (per_cnt_q == AP_LAST);
        per_cnt_d = per_cnt_q;
        if (!auto_en) begin
            per_cnt_d = '0;
        end else if (!hold) begin
            if (press_evt || per_cnt_q == AP_LAST) begin
                per_cnt_d = '0;
            end else begin
                per_cnt_d = per_cnt_q + ONE;
            end
        end
    end

    always_comb begin
        toggle      = (press_evt || auto_evt) && !hold;
        s_d         = s_q ^ toggle;
        s_changed_d = toggle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= RELEASED;
            db_cnt_q    <= '0;
            per_cnt_q   <= '0;
            s_q         <= 1'b0;
            s_changed_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            per_cnt_q   <= per_cnt_d;
            s_q         <= s_d;
            s_changed_q <= s_changed_d;
        end
    end

    assign s         = s_q;
    assign s_changed = s_changed_q;

`ifdef MUX_SEL_CTRL_TOGGLE_COUNT_EN
    logic [7:0] toggle_cnt_q, toggle_cnt_d;

    always_comb begin
        toggle_cnt_d = toggle_cnt_q;
        if (toggle) begin
            toggle_cnt_d = toggle_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            toggle_cnt_q <= 8'd0;
        end else begin
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    assign toggle_cnt = toggle_cnt_q;
`endif

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed testbench for mux_sel_ctrl with hand-derived edge-by-edge expectations.
// Exercises toggle_cnt as well when MUX_SEL_CTRL_TOGGLE_COUNT_EN is defined.
module tb_mux_sel_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic auto_en;
    logic hold;
    logic s;
    logic s_changed;
`ifdef MUX_SEL_CTRL_TOGGLE_COUNT_EN
    logic [7:0] toggle_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_s;
    logic exp_chg;

    always #5 clk = ~clk;

    mux_sel_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .auto_en   (auto_en),
        .hold      (hold),
        .s         (s),
        .s_changed (s_changed)
`ifdef MUX_SEL_CTRL_TOGGLE_COUNT_EN
        ,
        .toggle_cnt(toggle_cnt)
`endif
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        btn     = 1'b0;
        auto_en = 1'b0;
        hold    = 1'b0;
        #1;
        n_cmp++;
        if (s !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_s: got %b want 0", s);
        end
        n_cmp++;
        if (s_changed !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_s_changed: got %b want 0", s_changed);
        end
        step_n(3);
        rst = 1'b0;
        step_n(5);
        n_cmp++;
        if (s !== 1'b0 || s_changed !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_idle: got s=%b chg=%b want 0/0", s, s_changed);
        end
        exp_s = 1'b0;
    endtask

    task automatic test_clean_press();
        btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_chg = (k == 6);
            if (exp_chg) exp_s = ~exp_s;
            n_cmp++;
            if (s !== exp_s || s_changed !== exp_chg) begin
                n_bad++;
                $display("[TB] FAIL press1 edge %0d: got s=%b chg=%b want s=%b chg=%b",
                         k, s, s_changed, exp_s, exp_chg);
            end
        end
        btn = 1'b0;
        step_n(10);
        btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_chg = (k == 6);
            if (exp_chg) exp_s = ~exp_s;
            n_cmp++;
            if (s !== exp_s || s_changed !== exp_chg) begin
                n_bad++;
                $display("[TB] FAIL press2 edge %0d: got s=%b chg=%b want s=%b chg=%b",
                         k, s, s_changed, exp_s, exp_chg);
            end
        end
        btn = 1'b0;
        step_n(10);
    endtask

    task automatic test_reset_mid_debounce();
        btn = 1'b1;
        step_n(8);
        btn = 1'b0;
        step_n(10);
        exp_s = 1'b1;
        n_cmp++;
        if (s !== exp_s) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_pre: got s=%b want 1", s);
        end
        btn = 1'b1;
        step_n(4);
        #2 rst = 1'b1;
        #1;
        exp_s = 1'b0;
        n_cmp++;
        if (s !== 1'b0 || s_changed !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rst_mid_async: got s=%b chg=%b want 0/0", s, s_changed);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_chg = (k == 6);
            if (exp_chg) exp_s = ~exp_s;
            n_cmp++;
            if (s !== exp_s || s_changed !== exp_chg) begin
                n_bad++;
                $display("[TB] FAIL rst_mid_repress edge %0d: got s=%b chg=%b want s=%b chg=%b",
                         k, s, s_changed, exp_s, exp_chg);
            end
        end
        btn = 1'b0;
        step_n(10);
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 17; k++) begin
            btn = (k < 3) || (k >= 4 && k < 7);
            step();
            n_cmp++;
            if (s !== exp_s || s_changed !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL glitch edge %0d: got s=%b chg=%b want s=%b chg=0",
                         k + 1, s, s_changed, exp_s);
            end
        end
        btn = 1'b0;
    endtask

    task automatic test_auto();
        auto_en = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            exp_chg = (k % 10 == 0);
            if (exp_chg) exp_s = ~exp_s;
            n_cmp++;
            if (s !== exp_s || s_changed !== exp_chg) begin
                n_bad++;
                $display("[TB] FAIL auto edge %0d: got s=%b chg=%b want s=%b chg=%b",
                         k, s, s_changed, exp_s, exp_chg);
            end
        end
        auto_en = 1'b0;
        step();
    endtask

    task automatic test_collision();
        auto_en = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            if (k == 5)  btn = 1'b1;
            if (k == 11) btn = 1'b0;
            if (k == 21) btn = 1'b1;
            if (k == 31) btn = 1'b0;
            step();
            exp_chg = (k == 10) || (k == 20) || (k == 26) || (k == 36);
            if (exp_chg) exp_s = ~exp_s;
            n_cmp++;
            if (s !== exp_s || s_changed !== exp_chg) begin
                n_bad++;
                $display("[TB] FAIL collision edge %0d: got s=%b chg=%b want s=%b chg=%b",
                         k, s, s_changed, exp_s, exp_chg);
            end
        end
        auto_en = 1'b0;
        step();
    endtask

    task automatic test_hold();
        auto_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4)  hold = 1'b1;
            if (k == 6)  btn  = 1'b1;
            if (k == 16) btn  = 1'b0;
            if (k == 29) hold = 1'b0;
            step();
            exp_chg = (k == 35);
            if (exp_chg) exp_s = ~exp_s;
            n_cmp++;
            if (s !== exp_s || s_changed !== exp_chg) begin
                n_bad++;
                $display("[TB] FAIL hold edge %0d: got s=%b chg=%b want s=%b chg=%b",
                         k, s, s_changed, exp_s, exp_chg);
            end
        end
        auto_en = 1'b0;
        step();
    endtask

`ifdef MUX_SEL_CTRL_TOGGLE_COUNT_EN
    task automatic test_toggle_count();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (toggle_cnt !== 8'd0) begin
            n_bad++;
            $display("[TB] FAIL tcnt_reset: got %0d want 0", toggle_cnt);
        end
        @(negedge clk);
        rst     = 1'b0;
        auto_en = 1'b1;
        step_n(10);
        n_cmp++;
        if (toggle_cnt !== 8'd1) begin
            n_bad++;
            $display("[TB] FAIL tcnt_first: got %0d want 1", toggle_cnt);
        end
        step_n(2540);
        n_cmp++;
        if (toggle_cnt !== 8'd255) begin
            n_bad++;
            $display("[TB] FAIL tcnt_255: got %0d want 255", toggle_cnt);
        end
        step_n(10);
        n_cmp++;
        if (toggle_cnt !== 8'd0) begin
            n_bad++;
            $display("[TB] FAIL tcnt_wrap: got %0d want 0", toggle_cnt);
        end
        step_n(10);
        n_cmp++;
        if (toggle_cnt !== 8'd1) begin
            n_bad++;
            $display("[TB] FAIL tcnt_257: got %0d want 1", toggle_cnt);
        end
        auto_en = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_reset_mid_debounce();
        test_glitch();
        test_auto();
        test_collision();
        test_hold();
`ifdef MUX_SEL_CTRL_TOGGLE_COUNT_EN
        test_toggle_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
